// File: rtl/dff_p.sv
// dff_p: reference flip-flop bank. One data input feeds three parallel
// WIDTH-bit registers that differ only in reset style:
//   q          - no reset
//   q_syncrst  - loads RST_VAL on a clk edge that samples reset=1
//   q_asyncrst - forced to RST_VAL as soon as reset rises, released on clk
// Optional feature macro: DFF_P_EDGE_DETECT_EN adds registered per-bit
// rise/fall detectors referenced against q_syncrst.
`timescale 1ns/1ps
module dff_p #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
`ifdef DFF_P_EDGE_DETECT_EN
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_asyncrst,
    output logic [WIDTH-1:0] q_syncrst
);

    logic [WIDTH-1:0] plain_d;
    logic [WIDTH-1:0] plain_q;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] async_q;

    // Next-state for the plain and synchronously reset registers.
    always_comb begin
        plain_d = d;
        sync_d  = d;
        if (reset) begin
            sync_d = RST_VAL;
        end else begin
            sync_d = d;
        end
    end

    // Plain register: captures d on every edge, reset has no effect.
    always_ff @(posedge clk) begin
        plain_q <= plain_d;
    end

    // Synchronous-reset register: reset only acts on a sampled clk edge.
    always_ff @(posedge clk) begin
        sync_q <= sync_d;
    end

    // Async-assert register: reset clears it immediately, even between edges,
    // and it resumes capturing on the first edge that samples reset low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            async_q <= RST_VAL;
        end else begin
            async_q <= d;
        end
    end

    assign q          = plain_q;
    assign q_syncrst  = sync_q;
    assign q_asyncrst = async_q;

`ifdef DFF_P_EDGE_DETECT_EN
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] fall_q;

    // Per-bit transition detect of d against the previously captured value.
    always_comb begin
        rise_d = {WIDTH{1'b0}};
        fall_d = {WIDTH{1'b0}};
        if (reset) begin
            rise_d = {WIDTH{1'b0}};
            fall_d = {WIDTH{1'b0}};
        end else begin
            rise_d = d & ~sync_q;
            fall_d = ~d & sync_q;
        end
    end

    // Edge-detect output registers.
    always_ff @(posedge clk) begin
        rise_q <= rise_d;
        fall_q <= fall_d;
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule

// File: tb/tb_dff_p.sv
// Directed testbench for dff_p: a WIDTH=1/RST_VAL=0 instance and a
// WIDTH=8/RST_VAL=8'hA5 instance share one clock (rising edges at 5,15,25...).
`timescale 1ns/1ps
module tb_dff_p;

    logic       clk;
    logic       reset;
    logic [0:0] d1;
    logic [0:0] q1, qa1, qs1;
    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8, qa8, qs8;
`ifdef DFF_P_EDGE_DETECT_EN
    logic [0:0] rise1, fall1;
    logic [7:0] rise8, fall8;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    dff_p #(.WIDTH(1), .RST_VAL(1'b0)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .d          (d1),
`ifdef DFF_P_EDGE_DETECT_EN
        .rise       (rise1),
        .fall       (fall1),
`endif
        .q          (q1),
        .q_asyncrst (qa1),
        .q_syncrst  (qs1)
    );

    dff_p #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
        .clk        (clk),
        .reset      (rst8),
        .d          (d8),
`ifdef DFF_P_EDGE_DETECT_EN
        .rise       (rise8),
        .fall       (fall8),
`endif
        .q          (q8),
        .q_asyncrst (qa8),
        .q_syncrst  (qs8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic at(input realtime t);
        #(t - $realtime);
    endtask

    initial begin
        reset = 1'b0; d1 = 1'b0; rst8 = 1'b0; d8 = 8'h00;
        at(7.5);  reset = 1'b0; d1 = 1'b0;
        at(12.0);
        chk("init_q",      {7'b0, q1},  8'h00);
        chk("init_qs",     {7'b0, qs1}, 8'h00);
        chk("init_qa",     {7'b0, qa1}, 8'h00);
        // Reset and d change together.
        at(12.5); reset = 1'b1; d1 = 1'b1;
        at(13.0);
        chk("rst_imm_qa",  {7'b0, qa1}, 8'h00);
        at(16.0);
        chk("rst_edge_q",  {7'b0, q1},  8'h01);
        chk("rst_edge_qs", {7'b0, qs1}, 8'h00);
        chk("rst_edge_qa", {7'b0, qa1}, 8'h00);
        // Deassert mid-cycle: resettable outputs hold until the next edge.
        at(17.5); reset = 1'b0; d1 = 1'b1;
        at(18.0);
        chk("mid_qs",      {7'b0, qs1}, 8'h00);
        chk("mid_qa",      {7'b0, qa1}, 8'h00);
        at(26.0);
        chk("rel_q",       {7'b0, q1},  8'h01);
        chk("rel_qs",      {7'b0, qs1}, 8'h01);
        chk("rel_qa",      {7'b0, qa1}, 8'h01);
        // Short reset pulse with no clock edge inside.
        at(31.0); reset = 1'b1;
        at(32.0);
        chk("pulse_qa",    {7'b0, qa1}, 8'h00);
        chk("pulse_q",     {7'b0, q1},  8'h01);
        chk("pulse_qs",    {7'b0, qs1}, 8'h01);
        at(33.0); reset = 1'b0;
        at(34.0);
        chk("pulse_hold_qa", {7'b0, qa1}, 8'h00);
        at(36.0);
        chk("pulse_rec_qa",  {7'b0, qa1}, 8'h01);
        chk("pulse_rec_qs",  {7'b0, qs1}, 8'h01);

        // 8-bit instance with non-zero reset value.
        at(37.0); rst8 = 1'b1; d8 = 8'h3C;
        at(38.0);
        chk("w8_imm_qa",   qa8, 8'hA5);
        chk("w8_imm_qs",   qs8, 8'h00);
        at(46.0);
        chk("w8_rst_q",    q8,  8'h3C);
        chk("w8_rst_qs",   qs8, 8'hA5);
        chk("w8_rst_qa",   qa8, 8'hA5);
        at(47.0); rst8 = 1'b0;
        at(48.0);
        chk("w8_mid_qs",   qs8, 8'hA5);
        chk("w8_mid_qa",   qa8, 8'hA5);
        at(56.0);
        chk("w8_rel_q",    q8,  8'h3C);
        chk("w8_rel_qs",   qs8, 8'h3C);
        chk("w8_rel_qa",   qa8, 8'h3C);
        at(57.0); d8 = 8'hC3;
        at(66.0);
        chk("w8_run_q",    q8,  8'hC3);
        chk("w8_run_qs",   qs8, 8'hC3);
        chk("w8_run_qa",   qa8, 8'hC3);

`ifdef DFF_P_EDGE_DETECT_EN
        // d already 1 and captured; step 1->0->1->0 one change per edge.
        at(67.0); d1 = 1'b0;
        at(76.0);
        chk("ed_fall1_r",  {7'b0, rise1}, 8'h00);
        chk("ed_fall1_f",  {7'b0, fall1}, 8'h01);
        at(77.0); d1 = 1'b1;
        at(86.0);
        chk("ed_rise_r",   {7'b0, rise1}, 8'h01);
        chk("ed_rise_f",   {7'b0, fall1}, 8'h00);
        at(87.0); d1 = 1'b0;
        at(96.0);
        chk("ed_fall2_r",  {7'b0, rise1}, 8'h00);
        chk("ed_fall2_f",  {7'b0, fall1}, 8'h01);
        at(106.0);
        chk("ed_idle_r",   {7'b0, rise1}, 8'h00);
        chk("ed_idle_f",   {7'b0, fall1}, 8'h00);
        // A rising d under reset must not flag rise.
        at(107.0); reset = 1'b1; d1 = 1'b1;
        at(116.0);
        chk("ed_rst_r",    {7'b0, rise1}, 8'h00);
        chk("ed_rst_f",    {7'b0, fall1}, 8'h00);
        at(117.0); reset = 1'b0;
        at(126.0);
        chk("ed_post_r",   {7'b0, rise1}, 8'h01);
        chk("ed_w8_r",     rise8, 8'h00);
        chk("ed_w8_f",     fall8, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
